// File: rtl/mult_div_unit_pkg.sv
// Shared types for the HI/LO multiply/divide unit: word width, op encodings,
// FSM states and the 64-bit conditional negation used for sign correction.
package mult_div_unit_pkg;

  localparam int WORD = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } mdOp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdState_t;

  function automatic logic [63:0] Negate64(input logic [63:0] value, input logic enable);
    return enable ? -value : value;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit holding the MIPS HI/LO registers.
// One result bit per cycle on magnitudes, with sign correction applied in FIX.
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [WORD-1:0] operandA,
  input  logic [WORD-1:0] operandB,
  input  logic            mtWrite,
  input  logic            mtSel,
  input  logic [WORD-1:0] mtData,
  output logic            busy,
  output logic            done,
  output logic [WORD-1:0] hi,
  output logic [WORD-1:0] lo
);

  mdState_t        r_state;
  mdOp_t           r_op;
  logic [63:0]     r_acc;
  logic [WORD-1:0] r_opB;
  logic [5:0]      r_cnt;
  logic            r_negRes;
  logic            r_negRem;
  logic            r_busy;
  logic            r_done;
  logic [WORD-1:0] r_hi;
  logic [WORD-1:0] r_lo;

  logic            w_isSigned;
  logic            w_isDiv;
  logic            w_divZero;
  logic [WORD-1:0] w_magA;
  logic [WORD-1:0] w_magB;
  logic            w_divOp;
  logic [WORD:0]   w_sum;
  logic [WORD:0]   w_remShift;
  logic            w_ge;
  logic [WORD-1:0] w_remNext;
  logic [63:0]     w_accNext;

  assign w_isSigned = (op == MD_MULT) || (op == MD_DIV);
  assign w_isDiv    = (op == MD_DIV) || (op == MD_DIVU);
  assign w_divZero  = w_isDiv && (operandB == '0);
  assign w_magA     = (w_isSigned && operandA[WORD-1]) ? -operandA : operandA;
  assign w_magB     = (w_isSigned && operandB[WORD-1]) ? -operandB : operandB;
  assign w_divOp    = (r_op == MD_DIV) || (r_op == MD_DIVU);

  // Both ops share r_acc: multiply keeps {partial product, multiplier},
  // divide keeps {partial remainder, dividend shifting into quotient}.
  assign w_sum      = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_opB : '0)};
  assign w_remShift = {r_acc[63:32], r_acc[31]};
  assign w_ge       = w_remShift >= {1'b0, r_opB};
  assign w_remNext  = w_ge ? (w_remShift[WORD-1:0] - r_opB) : w_remShift[WORD-1:0];
  assign w_accNext  = w_divOp ? {w_remNext, r_acc[30:0], w_ge} : {w_sum, r_acc[31:1]};

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_op     <= MD_MULT;
      r_acc    <= '0;
      r_opB    <= '0;
      r_cnt    <= '0;
      r_negRes <= 1'b0;
      r_negRem <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op   <= mdOp_t'(op);
            r_opB  <= w_magB;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            // Divide by zero bypasses CALC with the architectural result preloaded.
            if (w_divZero) begin
              r_acc    <= {operandA, 32'hFFFF_FFFF};
              r_negRes <= 1'b0;
              r_negRem <= 1'b0;
              r_state  <= FIX;
            end else begin
              r_acc    <= {32'b0, w_magA};
              r_negRes <= w_isSigned && (operandA[WORD-1] ^ operandB[WORD-1]);
              r_negRem <= w_isSigned && w_isDiv && operandA[WORD-1];
              r_state  <= CALC;
            end
          end else if (mtWrite) begin
            if (mtSel) r_hi <= mtData;
            else       r_lo <= mtData;
          end
        end
        CALC: begin
          r_acc <= w_accNext;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd31) r_state <= FIX;
        end
        FIX: begin
          if (w_divOp) begin
            r_lo <= r_negRes ? -r_acc[31:0] : r_acc[31:0];
            r_hi <= r_negRem ? -r_acc[63:32] : r_acc[63:32];
          end else begin
            {r_hi, r_lo} <= Negate64(r_acc, r_negRes);
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: hand-computed HI/LO results,
// latency, done pulse, ignored requests while busy and reset mid-operation.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic        mtWrite;
  logic        mtSel;
  logic [31:0] mtData;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checkCount = 0;
  int errorCount = 0;

  mult_div_unit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .operandA (operandA),
    .operandB (operandB),
    .mtWrite  (mtWrite),
    .mtSel    (mtSel),
    .mtData   (mtData),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Issues start across one edge (edge 0) and returns #1 after it.
  task automatic applyStimulus(input logic [1:0] opIn, input logic [31:0] a, input logic [31:0] b);
    op       = opIn;
    operandA = a;
    operandB = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    operandA = 32'h5A5A_5A5A;
    operandB = 32'hA5A5_A5A5;
  endtask

  task automatic waitDone(inout int cycles);
    while (!done && cycles < 60) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic runOp(input string tag, input logic [1:0] opIn, input logic [31:0] a,
                       input logic [31:0] b, input int expLat, input logic [31:0] expHi,
                       input logic [31:0] expLo);
    int cycles;
    cycles = 0;
    applyStimulus(opIn, a, b);
    checkOutput({tag, " busyAfterStart"}, busy, 1);
    waitDone(cycles);
    checkOutput({tag, " latency"}, cycles, expLat);
    checkOutput({tag, " hi"}, hi, expHi);
    checkOutput({tag, " lo"}, lo, expLo);
    checkOutput({tag, " busyAtDone"}, busy, 0);
  endtask

  initial begin
    int cycles;
    bit sawDone;
    reset    = 1'b1;
    start    = 1'b0;
    op       = 2'd0;
    operandA = '0;
    operandB = '0;
    mtWrite  = 1'b0;
    mtSel    = 1'b0;
    mtData   = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetDone", done, 0);
    checkOutput("resetHi", hi, 0);
    checkOutput("resetLo", lo, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    runOp("multuMax", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h0000_0001);
    @(posedge clk);
    #1;
    checkOutput("multuMax donePulse", done, 0);
    checkOutput("multuMax hiHeld", hi, 32'hFFFF_FFFE);

    runOp("multNeg", 2'd0, 32'hFFFF_FFFD, 32'd5, 33, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    runOp("divNeg", 2'd2, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runOp("divu", 2'd3, 32'd100, 32'd7, 33, 32'd2, 32'd14);
    runOp("divuZero", 2'd3, 32'h1234_5678, 32'd0, 1, 32'h1234_5678, 32'hFFFF_FFFF);
    runOp("divZeroSigned", 2'd2, 32'hFFFF_FFF9, 32'd0, 1, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    runOp("divOverflow", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);
    runOp("multMixed", 2'd0, 32'h0001_0000, 32'hFFFF_0000, 33, 32'hFFFF_FFFF, 32'h0000_0000);

    // Back-to-back: the next start is issued in the done cycle.
    applyStimulus(2'd3, 32'd1000, 32'd3);
    checkOutput("b2b busyAfterStart", busy, 1);
    checkOutput("b2b doneCleared", done, 0);
    cycles = 0;
    waitDone(cycles);
    checkOutput("b2b latency", cycles, 33);
    checkOutput("b2b lo", lo, 32'd333);
    checkOutput("b2b hi", hi, 32'd1);

    // start and mtWrite together in IDLE: start wins.
    mtWrite = 1'b1;
    mtSel   = 1'b0;
    mtData  = 32'hDEAD_BEEF;
    applyStimulus(2'd3, 32'd100, 32'd7);
    mtWrite = 1'b0;
    cycles  = 0;
    waitDone(cycles);
    checkOutput("startBeatsMt lo", lo, 32'd14);

    // Requests during CALC are ignored.
    applyStimulus(2'd0, 32'd3, 32'd7);
    cycles = 0;
    repeat (9) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    start    = 1'b1;
    op       = 2'd2;
    operandA = 32'd50;
    operandB = 32'd5;
    mtWrite  = 1'b1;
    mtSel    = 1'b1;
    mtData   = 32'hAAAA_5555;
    @(posedge clk);
    #1;
    cycles++;
    start   = 1'b0;
    mtWrite = 1'b0;
    waitDone(cycles);
    checkOutput("ignore latency", cycles, 33);
    checkOutput("ignore hi", hi, 32'd0);
    checkOutput("ignore lo", lo, 32'd21);
    mtWrite = 1'b1;
    mtSel   = 1'b1;
    mtData  = 32'hAAAA_5555;
    @(posedge clk);
    #1;
    mtWrite = 1'b0;
    checkOutput("mthi hi", hi, 32'hAAAA_5555);
    checkOutput("mthi lo", lo, 32'd21);
    mtWrite = 1'b1;
    mtSel   = 1'b0;
    mtData  = 32'h0BAD_F00D;
    @(posedge clk);
    #1;
    mtWrite = 1'b0;
    checkOutput("mtlo lo", lo, 32'h0BAD_F00D);
    checkOutput("mtlo hi", hi, 32'hAAAA_5555);

    // Reset at edge 20 of a DIV abandons it.
    applyStimulus(2'd2, 32'd1000, 32'd3);
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("midReset busy", busy, 0);
    checkOutput("midReset hi", hi, 0);
    checkOutput("midReset lo", lo, 0);
    sawDone = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) sawDone = 1'b1;
    end
    checkOutput("midReset noDone", sawDone, 0);
    runOp("afterReset", 2'd3, 32'd100, 32'd7, 33, 32'd2, 32'd14);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
